// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for div/divu, one quotient bit per clock.
// Define DIV_SIGNED_EN to honour is_signed; without it every operation is unsigned.
module div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e           state_q;
   logic [CntW-1:0]  cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] raw_q;
   logic             dz_q;
   logic             busy_q;
   logic             done_q;
   logic             div_zero_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;

   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;

`ifdef DIV_SIGNED_EN
   logic dvd_neg;
   logic dvs_neg;
   logic neg_quo_q;
   logic neg_rem_q;

   always_comb begin
      dvd_neg = is_signed & dividend[WIDTH-1];
      dvs_neg = is_signed & divisor[WIDTH-1];
      dvd_mag = dvd_neg ? -dividend : dividend;
      dvs_mag = dvs_neg ? -divisor : divisor;
   end
`else
   logic unused_is_signed;

   assign unused_is_signed = is_signed;
   assign dvd_mag          = dividend;
   assign dvs_mag          = divisor;
`endif

   // One restoring step: remainder always stays below the divisor, so a
   // WIDTH+1-bit trial is enough to detect a borrow.
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             q_bit;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quo_step;

   always_comb begin
      shifted  = {rem_q, quo_q[WIDTH-1]};
      trial    = shifted - {1'b0, dvs_q};
      q_bit    = ~trial[WIDTH];
      rem_step = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], q_bit};
   end

   logic [WIDTH-1:0] fix_quo;
   logic [WIDTH-1:0] fix_rem;

   always_comb begin
      fix_quo = quo_q;
      fix_rem = rem_q;
`ifdef DIV_SIGNED_EN
      if (neg_quo_q) fix_quo = -quo_q;
      if (neg_rem_q) fix_rem = -rem_q;
`endif
      if (dz_q) begin
         fix_quo = '1;
         fix_rem = raw_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         raw_q       <= '0;
         dz_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
`ifdef DIV_SIGNED_EN
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            // DONE also accepts, so a start on the edge where done falls is taken.
            StIdle, StDone: begin
               if (start) begin
                  state_q <= StCalc;
                  busy_q  <= 1'b1;
                  cnt_q   <= CntW'(WIDTH - 1);
                  rem_q   <= '0;
                  quo_q   <= dvd_mag;
                  dvs_q   <= dvs_mag;
                  raw_q   <= dividend;
                  dz_q    <= (divisor == '0);
`ifdef DIV_SIGNED_EN
                  neg_quo_q <= dvd_neg ^ dvs_neg;
                  neg_rem_q <= dvd_neg;
`endif
               end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
            StCalc: begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               if (cnt_q == '0) begin
                  state_q <= StFix;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            StFix: begin
               quotient_q  <= fix_quo;
               remainder_q <= fix_rem;
               div_zero_q  <= dz_q;
               done_q      <= 1'b1;
               state_q     <= StDone;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign div_zero  = div_zero_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit; expectations are queued at launch, checked on done.
module tb_div_unit;

   localparam int unsigned W = 32;

   logic         clock;
   logic         reset_n;
   logic         start;
   logic         is_signed;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic         div_zero;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;

   div_unit #(.WIDTH(W)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .is_signed(is_signed),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .quotient (quotient),
      .remainder(remainder)
   );

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           acc;
      string        tag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   last_acc = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                               input string tag);
      exp_t e;
      e.q = q; e.r = r; e.dz = dz; e.acc = 0; e.tag = tag;
      return e;
   endfunction

   function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input string tag);
      exp_t e;
      logic use_signed;
`ifdef DIV_SIGNED_EN
      use_signed = sgn;
`else
      use_signed = sgn & 1'b0;
`endif
      e = mk('0, '0, 1'b0, tag);
      if (b == '0) begin
         e.q = '1; e.r = a; e.dz = 1'b1;
      end else if (use_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.q = 32'h8000_0000; e.r = '0;
      end else if (use_signed) begin
         e.q = 32'($signed(a) / $signed(b));
         e.r = 32'($signed(a) % $signed(b));
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   // Drives a request now; it is accepted on the next rising edge.
   task automatic launch(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e);
      start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
      @(posedge clock);
      #1;
      e.acc    = cyc;
      last_acc = cyc;
      sb.push_back(e);
      start = 1'b0;
      check_eq({e.tag, ".busy_rise"}, busy, 1'b1);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (busy && n < 200);
      check_eq({tag, ".busy_len"}, cyc - last_acc, W + 2);
      check_eq({tag, ".drained"}, sb.size(), 0);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!done && n < 200);
      check_eq({tag, ".done_seen"}, done, 1'b1);
   endtask

   always @(negedge clock) begin
      if (reset_n && done) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_done", done, 1'b0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_eq({e.tag, ".quotient"}, quotient, e.q);
            check_eq({e.tag, ".remainder"}, remainder, e.r);
            check_eq({e.tag, ".div_zero"}, div_zero, e.dz);
            check_eq({e.tag, ".latency"}, cyc - e.acc, W + 1);
            check_eq({e.tag, ".busy_at_done"}, busy, 1'b1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;

      reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
      #12;
      check_eq("rst.busy", busy, 1'b0);
      check_eq("rst.done", done, 1'b0);
      check_eq("rst.div_zero", div_zero, 1'b0);
      check_eq("rst.quotient", quotient, '0);
      check_eq("rst.remainder", remainder, '0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      launch(1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, "u100_7"));
      wait_idle("u100_7");
`ifdef DIV_SIGNED_EN
      launch(1'b1, 32'hFFFF_FFF9, 32'h2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "s_m7_2"));
      wait_idle("s_m7_2");
      launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, '0, 1'b0, "s_ovf"));
      wait_idle("s_ovf");
      launch(1'b1, 32'd7, 32'hFFFF_FFFE, mk(32'hFFFF_FFFD, 32'd1, 1'b0, "s_7_m2"));
      wait_idle("s_7_m2");
      launch(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, mk(32'd2, 32'hFFFF_FFFE, 1'b0, "s_m8_m3"));
      wait_idle("s_m8_m3");
`else
      launch(1'b1, 32'hFFFF_FFF9, 32'h2, mk(32'h7FFF_FFFC, 32'd1, 1'b0, "s_m7_2"));
      wait_idle("s_m7_2");
      launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mk('0, 32'h8000_0000, 1'b0, "s_ovf"));
      wait_idle("s_ovf");
      launch(1'b1, 32'd7, 32'hFFFF_FFFE, mk('0, 32'd7, 1'b0, "s_7_m2"));
      wait_idle("s_7_m2");
      launch(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, mk('0, 32'hFFFF_FFF8, 1'b0, "s_m8_m3"));
      wait_idle("s_m8_m3");
`endif
      launch(1'b0, 32'hFFFF_FFF9, 32'h2, mk(32'h7FFF_FFFC, 32'd1, 1'b0, "u_m7_2"));
      wait_idle("u_m7_2");
      launch(1'b1, 32'h1234_5678, '0, mk(32'hFFFF_FFFF, 32'h1234_5678, 1'b1, "s_dz"));
      wait_idle("s_dz");
      launch(1'b0, 32'h1234_5678, '0, mk(32'hFFFF_FFFF, 32'h1234_5678, 1'b1, "u_dz"));
      wait_idle("u_dz");
      launch(1'b0, 32'hFFFF_FFFF, 32'd1, mk(32'hFFFF_FFFF, '0, 1'b0, "u_max_1"));
      wait_idle("u_max_1");

      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         b = $urandom;
         s = 1'($urandom_range(0, 1));
         if (i % 3 == 0) b = W'($urandom_range(1, 15));
         if (i % 4 == 1) a[W-1] = 1'b1;
         if (i % 5 == 2) b = -b;
         launch(s, a, b, model(s, a, b, $sformatf("rnd%0d", i)));
         wait_idle($sformatf("rnd%0d", i));
      end

      // A second start mid-calculation must be dropped.
      launch(1'b0, 32'd1000, 32'd9, mk(32'd111, 32'd1, 1'b0, "ign"));
      repeat (4) @(posedge clock);
      #1;
      start = 1'b1; is_signed = 1'b1; dividend = 32'd5; divisor = 32'd1;
      @(posedge clock);
      #1;
      start = 1'b0;
      wait_idle("ign");

      // Start presented while done is high is taken on the edge where done falls.
      launch(1'b0, 32'd12345, 32'd100, mk(32'd123, 32'd45, 1'b0, "b2b_a"));
      wait_done("b2b_a");
      launch(1'b0, 32'h0000_FFFF, 32'h10, mk(32'h0000_0FFF, 32'hF, 1'b0, "b2b_b"));
      wait_idle("b2b_b");

      // Asynchronous reset mid-calculation.
      launch(1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, "abort"));
      repeat (9) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("abort.busy", busy, 1'b0);
      check_eq("abort.quotient", quotient, '0);
      check_eq("abort.remainder", remainder, '0);
      check_eq("abort.done", done, 1'b0);
      sb.delete();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (40) @(negedge clock);
      check_eq("abort.idle_busy", busy, 1'b0);
      launch(1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, "post_abort"));
      wait_idle("post_abort");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
